muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer beside the single-cycle ALU. It adds RV32M-style MUL, MULHU, DIVU and REMU without a combinational multiplier or divider.
- Decode raises start_i with the operands from the register file. The block runs a shift-add or restoring-divide loop over multiple cycles and drives stall_o so the PC and register write are held.
- It presents data_o with a one-cycle valid_o pulse for write-back.

Parameters:
XLEN, 32, operand and result width; iteration count equals XLEN.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-low (0 = reset).
start_i  input  1  request; sampled only in IDLE.
op_i  input  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU; sampled with start_i.
data1_i  input  XLEN  multiplicand / dividend.
data2_i  input  XLEN  multiplier / divisor.
busy_o  output  1  high in CALC and DONE.
stall_o  output  1  combinational: (IDLE and start_i) or CALC; holds PC and suppresses RegWrite.
valid_o  output  1  one-cycle pulse in DONE; data_o valid.
data_o  output  XLEN  result; held from DONE until the next accepted start.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; counter, internal registers and data_o = 0; busy_o = 0; valid_o = 0. stall_o follows its equation.
- States:
  - IDLE: on start_i=1, latch op_i and operands, clear the accumulator/remainder, counter=0, go to CALC.
  - CALC: one iteration per cycle; counter increments; after iteration XLEN-1 (counter==XLEN-1), go to DONE.
  - DONE: valid_o=1 and data_o updated in this cycle; next state is IDLE unconditionally.
- Latency: start sampled at edge N. valid_o is high during cycle N+XLEN+1 (XLEN CALC cycles plus DONE). stall_o is low in DONE, so the PC advances on the edge that ends DONE.
- MUL/MULHU: unsigned shift-add into a 2*XLEN product register. Each iteration tests multiplier bit 0, conditionally adds the multiplicand into the upper half, then shifts right 1.
  - MUL returns product[XLEN-1:0]; MULHU returns product[2*XLEN-1:XLEN].
- DIVU/REMU: restoring division using an XLEN+1-bit partial remainder. Each iteration shifts in the next dividend MSB, trial-subtracts the divisor, keeps the result if non-negative and sets the quotient bit.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero (data2_i==0 with op 10/11): IDLE goes directly to DONE, skipping CALC. valid_o is high in cycle N+1. DIVU returns all ones; REMU returns data1_i.
- start_i while busy_o=1 is ignored: no re-latch, no effect on the result.
- start_i held high across DONE is a new request only when it is sampled in IDLE.
- Operands may change after the start edge without affecting the result.
- Reset asserted mid-CALC aborts the operation: no valid_o pulse; after release the block is in IDLE.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: for MUL/MULHU, the residual multiplier register is checked after each CALC iteration. If it is zero, the block shifts the product right by the remaining iterations, goes to DONE next cycle and yields an identical result.
  - Example: data2_i=3 gives valid_o in cycle N+3.
  - Multiply by zero gives valid_o in cycle N+2.
  - Divide latency is unchanged.
- Undefined: all non-zero-divisor operations take fixed latency XLEN+1.

Test Plan:
- MUL 7 x 6, start at edge 0 -> stall_o high cycles 0-32, valid_o only in cycle 33, data_o=42; data_o still 42 after DONE.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> data_o=0xFFFFFFFE; MUL same operands -> data_o=0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000.
- DIVU 0x1234/0 -> valid_o in cycle 1, data_o=0xFFFFFFFF; REMU 0x1234/0 -> data_o=0x00001234.
- Start DIVU 50/5, then pulse start_i with MUL 2 x 3 at cycle 10 -> ignored; data_o=10 at cycle 33; no second valid_o.
- rst_i low at cycle 15 of a MUL -> busy_o, valid_o and data_o 0 immediately; no valid_o after release. Then a new MUL 3 x 3 -> 9.
- (MULDIV_EARLY_OUT_EN) MUL 0x12345678 x 3 -> data_o=0x369D0368 in cycle 3.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU), one iteration per clock.
// Optional early termination of multiplies when the residual multiplier is zero: MULDIV_EARLY_OUT_EN.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_t            state_reg, state_next;
  logic [1:0]        op_reg;
  logic [XLEN-1:0]   a_reg;     // multiplicand, or divisor
  logic [XLEN-1:0]   b_reg;     // residual multiplier, or dividend shifting into quotient
  logic [2*XLEN-1:0] prod_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   data_reg;

  logic              div_zero, finish, early_done;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] prod_step, prod_final;
  logic [XLEN-1:0]   b_mul_step;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [XLEN-1:0]   rem_step, q_step;
  logic [XLEN-1:0]   result;

  assign div_zero = op_i[1] && (data2_i == '0);

  // Shift-add step: add into the upper half with carry, then shift the whole product right.
  always_comb begin
    add_sum    = {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, (b_reg[0] ? a_reg : '0)};
    prod_step  = {add_sum, prod_reg[XLEN-1:1]};
    b_mul_step = b_reg >> 1;
  end

  // Restoring step: a negative trial difference shows up as a set MSB of the XLEN+1-bit result.
  always_comb begin
    rem_shift = {rem_reg, b_reg[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, a_reg};
    if (!rem_diff[XLEN]) begin
      rem_step = rem_diff[XLEN-1:0];
      q_step   = {b_reg[XLEN-2:0], 1'b1};
    end else begin
      rem_step = rem_shift[XLEN-1:0];
      q_step   = {b_reg[XLEN-2:0], 1'b0};
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] remaining;
  always_comb begin
    remaining  = LAST_ITER - cnt_reg;
    early_done = !op_reg[1] && (b_mul_step == '0);
    prod_final = prod_step >> remaining;
  end
`else
  always_comb begin
    early_done = 1'b0;
    prod_final = prod_step;
  end
`endif

  always_comb begin
    finish = (state_reg == CALC) && ((cnt_reg == LAST_ITER) || early_done);
    if (op_reg[1])
      result = op_reg[0] ? rem_step : q_step;
    else
      result = op_reg[0] ? prod_final[2*XLEN-1:XLEN] : prod_final[XLEN-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = div_zero ? DONE : CALC;
      CALC:    if (finish)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_reg == CALC) || (state_reg == DONE);
    valid_o = (state_reg == DONE);
    stall_o = ((state_reg == IDLE) && start_i) || (state_reg == CALC);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      prod_reg <= '0;
      rem_reg  <= '0;
      cnt_reg  <= '0;
      data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start_i) begin
          op_reg   <= op_i;
          a_reg    <= op_i[1] ? data2_i : data1_i;
          b_reg    <= op_i[1] ? data1_i : data2_i;
          prod_reg <= '0;
          rem_reg  <= '0;
          cnt_reg  <= '0;
          if (div_zero) data_reg <= op_i[0] ? data1_i : '1;
        end
        CALC: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (op_reg[1]) begin
            rem_reg <= rem_step;
            b_reg   <= q_step;
          end else begin
            prod_reg <= prod_step;
            b_reg    <= b_mul_step;
          end
          if (finish) data_reg <= result;
        end
        default: ;
      endcase
    end
  end

  assign data_o = data_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: latency/result model checked every cycle plus directed literal vectors.
// Honours MULDIV_EARLY_OUT_EN the same way the design does.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic [1:0]      op_i = '0;
  logic [XLEN-1:0] data1_i = '0;
  logic [XLEN-1:0] data2_i = '0;
  logic            busy_o, stall_o, valid_o;
  logic [XLEN-1:0] data_o;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i),
    .busy_o(busy_o), .stall_o(stall_o), .valid_o(valid_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the accepting edge to the cycle that shows valid_o.
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
    int k;
    if (op[1]) return (b == 0) ? 1 : XLEN + 1;
    k = XLEN;
`ifdef MULDIV_EARLY_OUT_EN
    k = 1;
    for (int i = 0; i < XLEN; i++) if (b[i]) k = i + 1;
`endif
    return k + 1;
  endfunction

  // Model: cycle index, start cycle and done cycle of the current request.
  int          cur = 0;
  int          m_start = -1;
  int          m_done = -1;
  logic [31:0] m_res = '0;
  logic [31:0] m_data = '0;

  function automatic bit m_busy(input int c);
    return (m_start >= 0) && (c > m_start) && (c <= m_done);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_start <= -1;
      m_done  <= -1;
      m_data  <= '0;
    end else begin
      if (!m_busy(cur) && start_i) begin
        m_start <= cur;
        m_done  <= cur + ref_latency(op_i, data2_i);
        m_res   <= ref_result(op_i, data1_i, data2_i);
        if (ref_latency(op_i, data2_i) == 1) m_data <= ref_result(op_i, data1_i, data2_i);
      end else if (m_start >= 0 && cur + 1 == m_done) begin
        m_data <= m_res;
      end
      cur <= cur + 1;
    end
  end

  always @(negedge clk_i) begin
    check("busy", busy_o, m_busy(cur));
    check("valid", valid_o, m_busy(cur) && cur == m_done);
    check("stall", stall_o, (!m_busy(cur) && start_i) || (m_busy(cur) && cur < m_done));
    check("data", data_o, m_data);
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk_i); #1;
    start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; op_i = 2'($urandom); data1_i = $urandom; data2_i = $urandom;
  endtask

  task automatic wait_valid(inout int k, output bit seen);
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk_i);
      k++;
      if (valid_o) seen = 1'b1;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_d, input int lat);
    int k;
    bit seen;
    k = 0;
    issue(op, a, b);
    wait_valid(k, seen);
    check("valid_seen", seen, 1);
    check("latency", k, lat);
    check("result", data_o, exp_d);
    @(negedge clk_i);
    check("held", data_o, exp_d);
    check("single_pulse", valid_o, 0);
    $display("op=%0d a=%h b=%h -> data=%h latency=%0d", op, a, b, data_o, k);
  endtask

  localparam int NV = 12;
  logic [1:0]  t_op   [NV] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
  logic [31:0] t_a    [NV] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000,
                               32'h1234, 32'h1234, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 32'd5};
  logic [31:0] t_b    [NV] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1,
                               32'd0, 32'd0, 32'd3, 32'd0, 32'h10, 32'd9};
  logic [31:0] t_exp  [NV] = '{32'd42, 32'hFFFF_FFFE, 32'h1, 32'd14, 32'd2, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'h1234, 32'h369D_0368, 32'h0, 32'hF, 32'h0};
  int          t_lat  [NV] = '{33, 33, 33, 33, 33, 33, 1, 1, 33, 33, 33, 33};
  int          t_late [NV] = '{4, 33, 33, 33, 33, 33, 1, 1, 3, 2, 33, 33};

  initial begin
    int k;
    int vcount;
    bit seen;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_busy", busy_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_data", data_o, 0);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
`ifdef MULDIV_EARLY_OUT_EN
      run(t_op[i], t_a[i], t_b[i], t_exp[i], t_late[i]);
`else
      run(t_op[i], t_a[i], t_b[i], t_exp[i], t_lat[i]);
`endif
    end

    // Start arriving while busy must be ignored.
    issue(2'd2, 32'd50, 32'd5);
    repeat (9) @(posedge clk_i);
    #1; start_i = 1'b1; op_i = 2'd0; data1_i = 32'd2; data2_i = 32'd3;
    @(posedge clk_i); #1; start_i = 1'b0;
    k = 10;
    wait_valid(k, seen);
    check("busy_start_seen", seen, 1);
    check("busy_start_latency", k, 33);
    check("busy_start_result", data_o, 32'd10);
    vcount = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    check("busy_start_no_second", vcount, 0);
    $display("op=2 a=50 b=5 with ignored MUL 2x3 -> data=%h", data_o);

    // Reset in the middle of a multiply aborts it.
    issue(2'd0, 32'hABCD, 32'h8000_1234);
    repeat (14) @(posedge clk_i);
    #1; rst_i = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_data", data_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    $display("reset mid-MUL -> busy=%b data=%h", busy_o, data_o);
    run(2'd0, 32'd3, 32'd3, 32'd9, ref_latency(2'd0, 32'd3));

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
